// File: rtl/boolean_sweep_pkg.sv
// Shared types and constants for the boolean sweep BIST controller.
package boolean_sweep_pkg;

    localparam int unsigned VEC_W            = 4;
    localparam int unsigned NUM_VEC          = 16;
    localparam int unsigned ERR_W            = 5;
    localparam logic [15:0] DEFAULT_EXPECTED = 16'hA5A5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } sweep_state_t;

endpackage

// File: rtl/boolean_sweep_ctrl.sv
// Self-checking sweep controller for a 4-input combinational function block.
// Drives vectors 0..15, waits SETTLE_CYCLES per vector, samples f_i into a
// truth table and compares it against EXPECTED.
// Optional macro BOOLEAN_SWEEP_FAIL_CAPTURE_EN adds first-failing-vector capture.
module boolean_sweep_ctrl
    import boolean_sweep_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter logic [15:0] EXPECTED      = DEFAULT_EXPECTED
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [VEC_W-1:0] vec_o,
    input  logic             f_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      captured,
`ifdef BOOLEAN_SWEEP_FAIL_CAPTURE_EN
    output logic [VEC_W-1:0] first_fail_vec,
    output logic             first_fail_valid,
`endif
    output logic [ERR_W-1:0] err_count
);

    localparam logic [3:0]       LP_SETTLE   = SETTLE_CYCLES[3:0];
    localparam logic [VEC_W-1:0] LP_LAST_IDX = VEC_W'(NUM_VEC - 1);

    sweep_state_t     r_state, w_state_nxt;
    logic [VEC_W-1:0] r_idx, w_idx_nxt;
    logic [3:0]       r_cnt, w_cnt_nxt;
    logic [15:0]      r_captured, w_captured_nxt;
    logic [ERR_W-1:0] r_err, w_err_nxt;
    logic             r_pass, w_pass_nxt;
    logic [VEC_W-1:0] r_vec, w_vec_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
`ifdef BOOLEAN_SWEEP_FAIL_CAPTURE_EN
    logic [VEC_W-1:0] r_ff_vec, w_ff_vec_nxt;
    logic             r_ff_valid, w_ff_valid_nxt;
`endif

    // Next-state, datapath and registered-output decode for the sweep FSM.
    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_cnt_nxt      = r_cnt;
        w_captured_nxt = r_captured;
        w_err_nxt      = r_err;
        w_pass_nxt     = r_pass;
`ifdef BOOLEAN_SWEEP_FAIL_CAPTURE_EN
        w_ff_vec_nxt   = r_ff_vec;
        w_ff_valid_nxt = r_ff_valid;
`endif
        unique case (r_state)
            ST_IDLE: begin
                if (start && !abort) begin
                    w_state_nxt    = ST_SETTLE;
                    w_idx_nxt      = '0;
                    w_cnt_nxt      = LP_SETTLE;
                    w_captured_nxt = '0;
                    w_err_nxt      = '0;
                    w_pass_nxt     = 1'b0;
`ifdef BOOLEAN_SWEEP_FAIL_CAPTURE_EN
                    w_ff_vec_nxt   = '0;
                    w_ff_valid_nxt = 1'b0;
`endif
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt <= 4'd1) begin
                    w_state_nxt = ST_SAMPLE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_SAMPLE: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_captured_nxt[r_idx] = f_i;
                    if (f_i != EXPECTED[r_idx]) begin
                        w_err_nxt = r_err + ERR_W'(1);
`ifdef BOOLEAN_SWEEP_FAIL_CAPTURE_EN
                        if (!r_ff_valid) begin
                            w_ff_vec_nxt   = r_idx;
                            w_ff_valid_nxt = 1'b1;
                        end
`endif
                    end
                    if (r_idx == LP_LAST_IDX) begin
                        // Forward the final count so pass is valid alongside done.
                        w_state_nxt = ST_DONE;
                        w_pass_nxt  = (w_err_nxt == '0);
                    end else begin
                        w_state_nxt = ST_SETTLE;
                        w_idx_nxt   = r_idx + VEC_W'(1);
                        w_cnt_nxt   = LP_SETTLE;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they land on registers.
        w_busy_nxt = (w_state_nxt == ST_SETTLE) || (w_state_nxt == ST_SAMPLE);
        w_done_nxt = (w_state_nxt == ST_DONE);
        w_vec_nxt  = w_busy_nxt ? w_idx_nxt : '0;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_captured <= '0;
            r_err      <= '0;
            r_pass     <= 1'b0;
            r_vec      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef BOOLEAN_SWEEP_FAIL_CAPTURE_EN
            r_ff_vec   <= '0;
            r_ff_valid <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_cnt      <= w_cnt_nxt;
            r_captured <= w_captured_nxt;
            r_err      <= w_err_nxt;
            r_pass     <= w_pass_nxt;
            r_vec      <= w_vec_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
`ifdef BOOLEAN_SWEEP_FAIL_CAPTURE_EN
            r_ff_vec   <= w_ff_vec_nxt;
            r_ff_valid <= w_ff_valid_nxt;
`endif
        end
    end

    assign vec_o     = r_vec;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign captured  = r_captured;
    assign err_count = r_err;
`ifdef BOOLEAN_SWEEP_FAIL_CAPTURE_EN
    assign first_fail_vec   = r_ff_vec;
    assign first_fail_valid = r_ff_valid;
`endif

endmodule

// File: tb/tb_boolean_sweep_ctrl.sv
// Scoreboard bench for boolean_sweep_ctrl. A behavioural function block
// (selectable: good, stuck-0, stuck-1, inverted) drives f_i from vec_o.
module tb_boolean_sweep_ctrl;
    import boolean_sweep_pkg::*;

    localparam int MODE_GOOD = 0;
    localparam int MODE_ZERO = 1;
    localparam int MODE_ONE  = 2;
    localparam int MODE_INV  = 3;

    typedef struct {
        logic [15:0] cap;
        logic [4:0]  err;
        logic        pass;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [3:0]  vec_o;
    logic        f_i;
    logic        busy, done, pass;
    logic [15:0] captured;
    logic [4:0]  err_count;
`ifdef BOOLEAN_SWEEP_FAIL_CAPTURE_EN
    logic [3:0]  first_fail_vec;
    logic        first_fail_valid;
`endif

    int   mode = MODE_GOOD;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb_q[$];

    boolean_sweep_ctrl #(.SETTLE_CYCLES(1), .EXPECTED(16'hA5A5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .vec_o     (vec_o),
        .f_i       (f_i),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .captured  (captured),
`ifdef BOOLEAN_SWEEP_FAIL_CAPTURE_EN
        .first_fail_vec   (first_fail_vec),
        .first_fail_valid (first_fail_valid),
`endif
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    function automatic logic f_of(input logic [3:0] v, input int m);
        logic b, d, good;
        b = v[2];
        d = v[0];
        good = (b & d) | (~b & ~d);
        case (m)
            MODE_ZERO: return 1'b0;
            MODE_ONE:  return 1'b1;
            MODE_INV:  return ~good;
            default:   return good;
        endcase
    endfunction

    assign f_i = f_of(vec_o, mode);

    function automatic exp_t predict(input int m);
        exp_t        e;
        logic [15:0] golden;
        logic        f;
        golden = 16'hA5A5;
        e.cap  = '0;
        e.err  = '0;
        for (int i = 0; i < 16; i++) begin
            f = f_of(4'(i), m);
            e.cap[i] = f;
            if (f != golden[i]) e.err = e.err + 5'd1;
        end
        e.pass = (e.err == 5'd0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_pulse();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_sweep(input int m);
        exp_t e;
        int   cycles;
        bit   seen;
        @(negedge clk);
        mode = m;
        sb_q.push_back(predict(m));
        start_pulse();
        seen = 0;
        cycles = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1 cycles++;
            if (done) begin
                seen = 1;
                break;
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("latency", 32'(cycles), 32'd32);
        chk("busy_with_done", 32'(busy), 32'd0);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("captured", 32'(captured), 32'(e.cap));
            chk("err_count", 32'(err_count), 32'(e.err));
            chk("pass", 32'(pass), 32'(e.pass));
        end
        @(posedge clk);
        #1 chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    task automatic wait_vec(input logic [3:0] v);
        bit found;
        found = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy && vec_o == v) begin
                found = 1;
                break;
            end
        end
        chk("wait_vec", 32'(found), 32'd1);
    endtask

    initial begin
        bit done_seen;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vec", 32'(vec_o), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_captured", 32'(captured), 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // Good function block
        run_sweep(MODE_GOOD);
`ifdef BOOLEAN_SWEEP_FAIL_CAPTURE_EN
        chk("ff_valid_good", 32'(first_fail_valid), 32'd0);
`endif

        // Abort during vector 5 settle
        mode = MODE_GOOD;
        start_pulse();
        #1 chk("busy_after_start", 32'(busy), 32'd1);
        chk("pass_cleared", 32'(pass), 32'd0);
        wait_vec(4'd5);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_vec", 32'(vec_o), 32'd0);
        chk("abort_cap_lo", 32'(captured[4:0]), 32'h05);
        chk("abort_cap_hi", 32'(captured[15:5]), 32'd0);
        chk("abort_err", 32'(err_count), 32'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1 if (done) done_seen = 1;
        end
        chk("abort_no_done", 32'(done_seen), 32'd0);
        chk("abort_pass", 32'(pass), 32'd0);

        // Stuck-at-0 output
        run_sweep(MODE_ZERO);

        // start together with abort in IDLE: ignored, results kept
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        abort = 1'b0;
        chk("sa_busy", 32'(busy), 32'd0);
        chk("sa_err_kept", 32'(err_count), 32'd8);
        @(posedge clk);
        #1 chk("sa_busy2", 32'(busy), 32'd0);

        // Inverted output
        run_sweep(MODE_INV);
`ifdef BOOLEAN_SWEEP_FAIL_CAPTURE_EN
        chk("ff_vec_inv", 32'(first_fail_vec), 32'd0);
        chk("ff_valid_inv", 32'(first_fail_valid), 32'd1);
`endif

        // Stuck-at-1 output
        run_sweep(MODE_ONE);
`ifdef BOOLEAN_SWEEP_FAIL_CAPTURE_EN
        chk("ff_vec_one", 32'(first_fail_vec), 32'd1);
        chk("ff_valid_one", 32'(first_fail_valid), 32'd1);
`endif

        // start while busy is ignored, then reset mid-sweep
        mode = MODE_GOOD;
        start_pulse();
        wait_vec(4'd3);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("busy_start_vec", 32'(vec_o), 32'd3);
        chk("busy_start_busy", 32'(busy), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_vec", 32'(vec_o), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_pass", 32'(pass), 32'd0);
        chk("mid_rst_cap", 32'(captured), 32'd0);
        chk("mid_rst_err", 32'(err_count), 32'd0);
`ifdef BOOLEAN_SWEEP_FAIL_CAPTURE_EN
        chk("mid_rst_ff_valid", 32'(first_fail_valid), 32'd0);
`endif
        @(negedge clk) rst_n = 1'b1;
        run_sweep(MODE_GOOD);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
